// File: rtl/wb_ic_pkg.sv
// wb_ic_pkg: shared arbiter state type, NO_MASTER constant and round-robin pick helper for the Wishbone interconnect
package wb_ic_pkg;
  typedef enum logic [1:0] {IDLE, OWN, WD_DRAIN} wb_arb_state_e;
  localparam logic [3:0] NO_MASTER = 4'hf;
  function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] last, input int n);
    logic [4:0] r;
    r = {1'b0, NO_MASTER};
    for (int i = 16; i >= 1; i--)
      if (i <= n && req[4'((int'(last) + i) % n)]) r = {1'b1, 4'((int'(last) + i) % n)};
    return r;
  endfunction
endpackage

// File: rtl/wb_wd_counter.sv
// wb_wd_counter: stall watchdog; clk, rstn, inc (stalled cycle), clr (response/idle) in; expire out on the TIMEOUT_CYCLES-th consecutive stall, never when TIMEOUT_CYCLES=0
module wb_wd_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  input  logic clr,
  output logic expire
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
  assign expire = TIMEOUT_CYCLES > 0 && inc && !clr && cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/wb_slave_arbiter.sv
// wb_slave_arbiter: per-slave round-robin owner arbiter with watchdog; req/cyc/stb_sel/s_ack/s_err in; gnt/gnt_id/gnt_vld/wd_err/wd_block out
module wb_slave_arbiter
  import wb_ic_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MASTERID_BITS  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_MASTERS-1:0]     req,
  input  logic [N_MASTERS-1:0]     cyc,
  input  logic                     stb_sel,
  input  logic                     s_ack,
  input  logic                     s_err,
  output logic [N_MASTERS-1:0]     gnt,
  output logic [MASTERID_BITS-1:0] gnt_id,
  output logic                     gnt_vld,
  output logic                     wd_err,
  output logic                     wd_block
);
  wb_arb_state_e state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [MASTERID_BITS-1:0] gnt_id_q, gnt_id_d, last_q, last_d;
  logic gnt_vld_q, gnt_vld_d;
  logic [4:0] pick;
  logic own_cyc, stall, expire;
  assign own_cyc = cyc[gnt_id_q];
  assign stall = state_q == OWN && stb_sel && !s_ack && !s_err;
  wb_wd_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .rstn(rstn),
    .inc(stall),
    .clr(!stall),
    .expire(expire)
  );
  always_comb begin
    pick = rr_pick(16'(req), 4'(last_q), N_MASTERS);
    state_d = state_q;
    gnt_d = gnt_q;
    gnt_id_d = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    last_d = last_q;
    if (state_q == IDLE && pick[4]) begin
      state_d = OWN;
      gnt_d = N_MASTERS'(1) << pick[3:0];
      gnt_id_d = MASTERID_BITS'(pick[3:0]);
      gnt_vld_d = 1'b1;
      last_d = MASTERID_BITS'(pick[3:0]);
    end else if (state_q != IDLE && !own_cyc) begin
      state_d = IDLE;
      gnt_d = '0;
      gnt_id_d = '0;
      gnt_vld_d = 1'b0;
    end else if (state_q == OWN && expire) begin
      state_d = WD_DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q <= '0;
      gnt_id_q <= '0;
      gnt_vld_q <= 1'b0;
      last_q <= MASTERID_BITS'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      last_q <= last_d;
    end
  end
  assign gnt = gnt_q;
  assign gnt_id = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign wd_err = state_q == OWN && own_cyc && expire;
  assign wd_block = state_q == WD_DRAIN;
endmodule

// File: tb/tb_wb_slave_arbiter.sv
// tb_wb_slave_arbiter: directed checks of reset, round robin, grant hold, watchdog, races and mid-op reset
module tb_wb_slave_arbiter;
  logic clk = 1'b0;
  logic rstn;
  logic [3:0] req, cyc;
  logic stb_sel, s_ack, s_err;
  logic [3:0] gnt, gnt0;
  logic [1:0] gnt_id, gnt_id0;
  logic gnt_vld, gnt_vld0, wd_err, wd_err0, wd_block, wd_block0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_slave_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .cyc(cyc), .stb_sel(stb_sel), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .wd_err(wd_err), .wd_block(wd_block)
  );
  wb_slave_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req(req), .cyc(cyc), .stb_sel(stb_sel), .s_ack(s_ack), .s_err(s_err),
    .gnt(gnt0), .gnt_id(gnt_id0), .gnt_vld(gnt_vld0), .wd_err(wd_err0), .wd_block(wd_block0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_owner(input int idx, input logic [3:0] new_req);
    cyc[idx] = 1'b0;
    req = new_req;
    step();
    cyc = 4'b1111;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 4'b1111; cyc = 4'b1111; stb_sel = 1'b0; s_ack = 1'b0; s_err = 1'b0;
    repeat (3) step();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
    checks++; if (gnt_vld !== 1'b0) begin errors++; $display("FAIL reset_gnt_vld got=%b exp=0", gnt_vld); end
    checks++; if (wd_err !== 1'b0 || wd_block !== 1'b0) begin errors++; $display("FAIL reset_wd got=%b%b exp=00", wd_err, wd_block); end
    rstn = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin errors++; $display("FAIL reset_first_grant got=%b/%0d/%b exp=0001/0/1", gnt, gnt_id, gnt_vld); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) begin
      checks++; if (gnt !== 4'(1 << k) || gnt_id !== 2'(k)) begin errors++; $display("FAIL rr_owner%0d got=%b/%0d exp=%b/%0d", k, gnt, gnt_id, 4'(1 << k), k); end
      stb_sel = 1'b1; s_ack = 1'b1;
      repeat (2) step();
      stb_sel = 1'b0; s_ack = 1'b0;
      cyc[k] = 1'b0;
      step();
      checks++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin errors++; $display("FAIL rr_idle%0d got=%b/%b exp=0000/0", k, gnt, gnt_vld); end
      cyc = 4'b1111;
      step();
    end
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got=%b exp=0001", gnt); end
  endtask

  task automatic test_hold();
    release_owner(0, 4'b0100);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_owner2 got=%b exp=0100", gnt); end
    req = 4'b0111;
    repeat (3) step();
    checks++; if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin errors++; $display("FAIL hold_frozen got=%b/%0d exp=0100/2", gnt, gnt_id); end
    release_owner(2, 4'b1011);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL hold_next3 got=%b exp=1000", gnt); end
    release_owner(3, 4'b0100);
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_again2 got=%b exp=0100", gnt); end
    release_owner(2, 4'b0011);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold_next0 got=%b exp=0001", gnt); end
  endtask

  task automatic test_watchdog();
    int early = 0;
    stb_sel = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (wd_err !== 1'b0) early++;
      step();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL wd_early got=%0d pulses exp=0", early); end
    checks++; if (wd_err !== 1'b1 || wd_block !== 1'b0) begin errors++; $display("FAIL wd_expire got=%b/%b exp=1/0", wd_err, wd_block); end
    step();
    checks++; if (wd_err !== 1'b0 || wd_block !== 1'b1 || gnt !== 4'b0001) begin errors++; $display("FAIL wd_drain got=%b/%b/%b exp=0/1/0001", wd_err, wd_block, gnt); end
    s_ack = 1'b1;
    step();
    checks++; if (wd_block !== 1'b1 || wd_err !== 1'b0) begin errors++; $display("FAIL wd_late_ack got=%b/%b exp=1/0", wd_block, wd_err); end
    s_ack = 1'b0; stb_sel = 1'b0; cyc[0] = 1'b0; req = 4'b0000;
    step();
    checks++; if (wd_block !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL wd_exit got=%b/%b exp=0/0000", wd_block, gnt); end
  endtask

  task automatic test_race();
    cyc = 4'b1111; req = 4'b0010;
    step();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL race_owner got=%b exp=0010", gnt); end
    stb_sel = 1'b1;
    repeat (7) step();
    s_ack = 1'b1;
    #1;
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL race_ack_wins got=%b exp=0", wd_err); end
    step();
    s_ack = 1'b0;
    repeat (6) step();
    checks++; if (wd_err !== 1'b0 || wd_block !== 1'b0) begin errors++; $display("FAIL race_cnt_clear got=%b/%b exp=0/0", wd_err, wd_block); end
    step();
    checks++; if (wd_err !== 1'b1) begin errors++; $display("FAIL race_reexpire got=%b exp=1", wd_err); end
    cyc[1] = 1'b0;
    #1;
    checks++; if (wd_err !== 1'b0) begin errors++; $display("FAIL race_cyc_drop got=%b exp=0", wd_err); end
    step();
    checks++; if (wd_block !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL race_idle got=%b/%b exp=0/0000", wd_block, gnt); end
  endtask

  task automatic test_no_watchdog();
    int seen = 0;
    stb_sel = 1'b0; cyc = 4'b1111; req = 4'b0100;
    step();
    checks++; if (gnt0 !== 4'b0100 || gnt !== 4'b0100) begin errors++; $display("FAIL nowd_owner got=%b/%b exp=0100", gnt0, gnt); end
    stb_sel = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (wd_err0 !== 1'b0 || wd_block0 !== 1'b0) seen++;
      step();
    end
    checks++; if (seen != 0 || gnt_vld0 !== 1'b1) begin errors++; $display("FAIL nowd_stall got=%0d/%b exp=0/1", seen, gnt_vld0); end
  endtask

  task automatic test_mid_reset();
    checks++; if (wd_block !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", wd_block); end
    rstn = 1'b0;
    step();
    checks++; if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || wd_block !== 1'b0) begin errors++; $display("FAIL midrst_clear got=%b/%b/%b exp=0000/0/0", gnt, gnt_vld, wd_block); end
    rstn = 1'b1; stb_sel = 1'b0; req = 4'b1111; cyc = 4'b1111;
    step();
    checks++; if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin errors++; $display("FAIL midrst_last got=%b/%0d exp=0001/0", gnt, gnt_id); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold();
    test_watchdog();
    test_race();
    test_no_watchdog();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
